cacheline_arbiter: RTL and testbench
====================================

# cacheline_arbiter

Arbitrates 256-bit cacheline requests from the instruction cache (read-only) and the data cache (read/write) onto the single LLC-side port of the cacheline adaptor. It sits directly upstream of the adaptor: the caches talk to this block, and this block drives the adaptor's `line_i` / `address_i` / `read_i` / `write_i` and consumes its `line_o` / `resp_o`. One transaction is outstanding at a time. Grant is round-robin, so neither cache starves.

## Interface
- `LINE_W`, 256, cacheline width in bits
- `ADDR_W`, 32, address width in bits

Ports:
- `clk` in 1: single clock, all state on rising edge
- `rst` in 1: synchronous, active-high reset
- `i_address` in ADDR_W: I-cache line address
- `i_read` in 1: I-cache read request, held until `i_resp`
- `i_rdata` out LINE_W: line returned to I-cache
- `i_resp` out 1: I-cache completion, one cycle
- `d_address` in ADDR_W: D-cache line address
- `d_read` in 1: D-cache read request, held until `d_resp`
- `d_write` in 1: D-cache write-back request, held until `d_resp`
- `d_wdata` in LINE_W: D-cache write-back line
- `d_rdata` out LINE_W: line returned to D-cache
- `d_resp` out 1: D-cache completion, one cycle
- `address_o` out ADDR_W: to adaptor `address_i`
- `line_o` out LINE_W: to adaptor `line_i`
- `read_o` out 1: to adaptor `read_i`
- `write_o` out 1: to adaptor `write_i`
- `line_i` in LINE_W: from adaptor `line_o`
- `resp_i` in 1: from adaptor `resp_o`

## Operation
- FSM states: `ARB_IDLE`, `ARB_ICACHE`, `ARB_DCACHE`. There is also a 1-bit `last_grant` register (I or D).
- In `ARB_IDLE`, a pending request is `i_read` or `d_read|d_write`.
  - Only one side pending: grant that side.
  - Both pending: grant the side not equal to `last_grant`.
- On grant, the block registers the following and updates `last_grant`:
  - `address_o` from the granted address;
  - `line_o` from `d_wdata` (D grant) or zero (I grant);
  - `read_o` / `write_o`.
- A D-side grant with both `d_read` and `d_write` high is illegal. It is treated as a write: `write_o=1`, `read_o=0`.
- In `ARB_ICACHE` / `ARB_DCACHE`, the registered outputs stay stable until `resp_i`. Input address and data changes are ignored.
- On a `resp_i` cycle:
  - the granted side's resp is asserted combinationally in the same cycle;
  - `read_o`, `write_o` and the FSM return to 0 / `ARB_IDLE` at the next edge.
- `i_rdata` and `d_rdata` are both wired directly to `line_i`. They are meaningful only when the matching resp is high.
- `resp_i` in `ARB_IDLE` is ignored: no resp is forwarded and no state change occurs.
- Requesters deassert their request in the cycle after seeing resp.

## Timing
- Reset values:
  - state `ARB_IDLE`, `last_grant`=D (so I wins the first tie);
  - `read_o`=`write_o`=0, `address_o`=0, `line_o`=0;
  - `i_resp`=`d_resp`=0.
- Request first seen in `ARB_IDLE` at cycle N: `read_o` / `write_o` high from cycle N+1.
- `resp_i` at cycle M: the requester resp is high in cycle M; `read_o` / `write_o` are low in cycle M+1.
- The earliest next grant is evaluated in cycle M+1, with outputs from M+2. This gives exactly one idle cycle between back-to-back transactions.
- `rst` mid-transaction: state, registered outputs and `last_grant` all return to their reset values at the next edge. The pending transaction is dropped, and no resp is issued for it.
- Simultaneous `rst` and `resp_i`: reset wins, and no requester resp is asserted.

## Structure
- Shared package `arbiter_types`:
  - `typedef enum logic [1:0] arb_state_t {ARB_IDLE, ARB_ICACHE, ARB_DCACHE}`;
  - `typedef enum logic grant_t {GRANT_I, GRANT_D}`;
  - localparams `LINE_W`=256, `ADDR_W`=32.
- No sub-module. The design is a single FSM plus an output register bank, roughly 150 lines.

## Test plan
- Single I read: `i_read`=1 at addr 0x0000_1000 at cycle 0.
  - Expect `read_o`=1 and `address_o`=0x1000 at cycle 1.
  - Drive `resp_i` with `line_i`=0xA5…A5 at cycle 5: `i_resp`=1 and `i_rdata`=0xA5…A5 at cycle 5; `read_o`=0 at cycle 6.
- D write-back: `d_write` at 0x2000 with `d_wdata`=0x1234…
  - Expect `write_o`=1, `line_o`=0x1234…, `address_o`=0x2000.
  - On `resp_i`, expect `d_resp`=1 and `i_resp`=0.
- Tie after reset: `i_read` and `d_read` both asserted at cycle 0.
  - I is granted first.
  - After its `resp_i`, D is granted with `read_o` rising 2 cycles after the resp.
  - A repeated tie then grants I again.
- Stability: change `d_address` and `d_wdata` mid-transaction.
  - `address_o` and `line_o` stay unchanged until `resp_i`.
- Reset mid-operation: assert `rst` while in `ARB_DCACHE` with `write_o`=1.
  - Next cycle: all outputs are 0, state is `ARB_IDLE`, and a later `resp_i` produces no resp to either side.

Source files
------------

// File: rtl/cacheline_arbiter_pkg.sv
// Shared types and widths for the I/D cacheline arbiter.
package arbiter_types;

  localparam int unsigned LINE_W = 256;
  localparam int unsigned ADDR_W = 32;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ICACHE = 2'd1,
    ARB_DCACHE = 2'd2
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

endpackage

// File: rtl/cacheline_arbiter.sv
// Round-robin arbiter putting I-cache reads and D-cache reads/write-backs
// onto the single LLC-side cacheline adaptor port, one transaction at a time.
module cacheline_arbiter
  import arbiter_types::*;
(
  input  logic              clk,
  input  logic              rst,
  // I-cache side
  input  logic [ADDR_W-1:0] i_address,
  input  logic              i_read,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  // D-cache side
  input  logic [ADDR_W-1:0] d_address,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  // adaptor side
  output logic [ADDR_W-1:0] address_o,
  output logic [LINE_W-1:0] line_o,
  output logic              read_o,
  output logic              write_o,
  input  logic [LINE_W-1:0] line_i,
  input  logic              resp_i
);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  grant_t            r_last_grant;
  grant_t            w_last_grant_nxt;
  logic [ADDR_W-1:0] r_address;
  logic [ADDR_W-1:0] w_address_nxt;
  logic [LINE_W-1:0] r_line;
  logic [LINE_W-1:0] w_line_nxt;
  logic              r_read;
  logic              w_read_nxt;
  logic              r_write;
  logic              w_write_nxt;

  logic              w_i_pend;
  logic              w_d_pend;
  logic              w_grant_d;

  assign w_i_pend  = i_read;
  assign w_d_pend  = d_read | d_write;
  // D wins when it is alone, or on a tie when I was served last.
  assign w_grant_d = w_d_pend & (~w_i_pend | (r_last_grant == GRANT_I));

  // State and adaptor-side output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= GRANT_D;
      r_address    <= '0;
      r_line       <= '0;
      r_read       <= 1'b0;
      r_write      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_address    <= w_address_nxt;
      r_line       <= w_line_nxt;
      r_read       <= w_read_nxt;
      r_write      <= w_write_nxt;
    end
  end

  // Next-state and next-output selection; everything holds by default.
  always_comb begin
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_address_nxt    = r_address;
    w_line_nxt       = r_line;
    w_read_nxt       = r_read;
    w_write_nxt      = r_write;
    unique case (r_state)
      ARB_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt      = ARB_DCACHE;
          w_last_grant_nxt = GRANT_D;
          w_address_nxt    = d_address;
          w_line_nxt       = d_wdata;
          // read+write together is illegal; treat it as a write-back
          w_write_nxt      = d_write;
          w_read_nxt       = ~d_write;
        end else if (w_i_pend) begin
          w_state_nxt      = ARB_ICACHE;
          w_last_grant_nxt = GRANT_I;
          w_address_nxt    = i_address;
          w_line_nxt       = '0;
          w_read_nxt       = 1'b1;
          w_write_nxt      = 1'b0;
        end
      end
      ARB_ICACHE, ARB_DCACHE: begin
        if (resp_i) begin
          w_state_nxt = ARB_IDLE;
          w_read_nxt  = 1'b0;
          w_write_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = ARB_IDLE;
        w_read_nxt  = 1'b0;
        w_write_nxt = 1'b0;
      end
    endcase
  end

  // Completion is forwarded in the resp cycle itself; reset suppresses it.
  assign i_resp    = resp_i & ~rst & (r_state == ARB_ICACHE);
  assign d_resp    = resp_i & ~rst & (r_state == ARB_DCACHE);
  assign i_rdata   = line_i;
  assign d_rdata   = line_i;

  assign address_o = r_address;
  assign line_o    = r_line;
  assign read_o    = r_read;
  assign write_o   = r_write;

endmodule

// File: tb/tb_cacheline_arbiter.sv
// Directed self-checking bench for cacheline_arbiter.
`timescale 1ns/1ps
module tb_cacheline_arbiter;
  import arbiter_types::*;

  logic              clk;
  logic              rst;
  logic [ADDR_W-1:0] i_address;
  logic              i_read;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;
  logic [ADDR_W-1:0] d_address;
  logic              d_read;
  logic              d_write;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;
  logic [ADDR_W-1:0] address_o;
  logic [LINE_W-1:0] line_o;
  logic              read_o;
  logic              write_o;
  logic [LINE_W-1:0] line_i;
  logic              resp_i;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [LINE_W-1:0] LINE_A5 = {32{8'hA5}};
  localparam logic [LINE_W-1:0] LINE_12 = {8{32'h1234_5678}};
  localparam logic [LINE_W-1:0] LINE_5A = {32{8'h5A}};
  localparam logic [LINE_W-1:0] LINE_C3 = {32{8'hC3}};

  cacheline_arbiter u_dut (
    .clk       (clk),
    .rst       (rst),
    .i_address (i_address),
    .i_read    (i_read),
    .i_rdata   (i_rdata),
    .i_resp    (i_resp),
    .d_address (d_address),
    .d_read    (d_read),
    .d_write   (d_write),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_resp    (d_resp),
    .address_o (address_o),
    .line_o    (line_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .line_i    (line_i),
    .resp_i    (resp_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [LINE_W-1:0] got,
                           input logic [LINE_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge (start of the next cycle).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle after driving inputs mid-cycle.
  task automatic settle();
    #1;
  endtask

  initial begin
    rst = 1'b1; i_address = '0; i_read = 1'b0; d_address = '0; d_read = 1'b0;
    d_write = 1'b0; d_wdata = '0; line_i = '0; resp_i = 1'b0;
    step(); step();
    rst = 1'b0;
    settle();
    check_val("rst_read_o",  256'(read_o),    256'(0));
    check_val("rst_write_o", 256'(write_o),   256'(0));
    check_val("rst_addr_o",  256'(address_o), 256'(0));
    check_val("rst_line_o",  line_o,          '0);

    // resp_i while idle is ignored
    resp_i = 1'b1; settle();
    check_val("idle_resp_i", 256'(i_resp), 256'(0));
    check_val("idle_resp_d", 256'(d_resp), 256'(0));
    step(); resp_i = 1'b0; settle();
    check_val("idle_resp_read_o", 256'(read_o), 256'(0));

    // single I read: request at cycle 0, resp at cycle 5
    i_address = 32'h0000_1000; i_read = 1'b1; settle();
    check_val("i0_read_o_c0", 256'(read_o), 256'(0));
    step();                                      // cycle 1
    check_val("i0_read_o_c1", 256'(read_o),    256'(1));
    check_val("i0_addr_c1",   256'(address_o), 256'(32'h1000));
    check_val("i0_line_c1",   line_o,          '0);
    check_val("i0_write_c1",  256'(write_o),   256'(0));
    step(); step(); step(); step();              // cycle 5
    check_val("i0_noresp_c5", 256'(i_resp), 256'(0));
    resp_i = 1'b1; line_i = LINE_A5; settle();
    check_val("i0_i_resp",  256'(i_resp), 256'(1));
    check_val("i0_d_resp",  256'(d_resp), 256'(0));
    check_val("i0_i_rdata", i_rdata,      LINE_A5);
    step();                                      // cycle 6
    resp_i = 1'b0; i_read = 1'b0; settle();
    check_val("i0_read_o_c6", 256'(read_o), 256'(0));

    // D write-back with mid-transaction input changes
    step();
    d_address = 32'h0000_2000; d_wdata = LINE_12; d_write = 1'b1;
    step();
    check_val("dw_write_o", 256'(write_o),   256'(1));
    check_val("dw_read_o",  256'(read_o),    256'(0));
    check_val("dw_line_o",  line_o,          LINE_12);
    check_val("dw_addr_o",  256'(address_o), 256'(32'h2000));
    d_address = 32'h0000_3000; d_wdata = LINE_5A;
    step(); step();
    check_val("dw_stable_addr", 256'(address_o), 256'(32'h2000));
    check_val("dw_stable_line", line_o,          LINE_12);
    check_val("dw_hold_write",  256'(write_o),   256'(1));
    check_val("dw_no_early_resp", 256'(d_resp),  256'(0));
    resp_i = 1'b1; line_i = LINE_C3; settle();
    check_val("dw_d_resp",  256'(d_resp), 256'(1));
    check_val("dw_i_resp",  256'(i_resp), 256'(0));
    check_val("dw_d_rdata", d_rdata,      LINE_C3);
    step();
    resp_i = 1'b0; d_write = 1'b0; settle();
    check_val("dw_write_o_done", 256'(write_o), 256'(0));

    // tie right after reset: I first, then D, then I again
    rst = 1'b1; step(); rst = 1'b0;
    i_address = 32'h0000_4000; i_read = 1'b1;
    d_address = 32'h0000_5000; d_read = 1'b1; d_wdata = LINE_5A;
    step();
    check_val("tie1_read_o", 256'(read_o),    256'(1));
    check_val("tie1_addr_o", 256'(address_o), 256'(32'h4000));
    step();
    resp_i = 1'b1; line_i = LINE_A5; settle();   // cycle M
    check_val("tie1_i_resp", 256'(i_resp), 256'(1));
    check_val("tie1_d_resp", 256'(d_resp), 256'(0));
    step();                                      // cycle M+1
    resp_i = 1'b0; i_read = 1'b0; settle();
    check_val("tie_gap_read_o", 256'(read_o), 256'(0));
    step();                                      // cycle M+2
    check_val("tie2_read_o", 256'(read_o),    256'(1));
    check_val("tie2_addr_o", 256'(address_o), 256'(32'h5000));
    check_val("tie2_line_o", line_o,          LINE_5A);
    resp_i = 1'b1; settle();
    check_val("tie2_d_resp", 256'(d_resp), 256'(1));
    check_val("tie2_i_resp", 256'(i_resp), 256'(0));
    step();
    resp_i = 1'b0; d_read = 1'b0;
    step();
    i_read = 1'b1; d_read = 1'b1;
    step();
    check_val("tie3_addr_o", 256'(address_o), 256'(32'h4000));
    check_val("tie3_line_o", line_o,          '0);
    resp_i = 1'b1; settle();
    check_val("tie3_i_resp", 256'(i_resp), 256'(1));
    step();
    resp_i = 1'b0; i_read = 1'b0;
    // D wins the next grant unopposed; both read and write high -> write
    d_write = 1'b1; d_address = 32'h0000_6000; d_wdata = LINE_12;
    step();
    check_val("ill_write_o", 256'(write_o),   256'(1));
    check_val("ill_read_o",  256'(read_o),    256'(0));
    check_val("ill_addr_o",  256'(address_o), 256'(32'h6000));

    // reset mid-transaction, simultaneous with resp_i
    rst = 1'b1; resp_i = 1'b1; settle();
    check_val("rst_resp_d", 256'(d_resp), 256'(0));
    check_val("rst_resp_i", 256'(i_resp), 256'(0));
    step();
    rst = 1'b0; resp_i = 1'b0; d_read = 1'b0; d_write = 1'b0; settle();
    check_val("midrst_write_o", 256'(write_o),   256'(0));
    check_val("midrst_read_o",  256'(read_o),    256'(0));
    check_val("midrst_addr_o",  256'(address_o), 256'(0));
    check_val("midrst_line_o",  line_o,          '0);
    step();
    resp_i = 1'b1; settle();
    check_val("midrst_late_d_resp", 256'(d_resp), 256'(0));
    check_val("midrst_late_i_resp", 256'(i_resp), 256'(0));
    step();
    resp_i = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
